// File: rtl/zl_ts_null_insert.sv
// MPEG-TS null-packet inserter: passes whole 188-byte packets from a show-ahead FIFO when a full
// packet is buffered, otherwise emits a null packet (PID 0x1FFF) to keep the output rate constant.
module zl_ts_null_insert #(
  parameter int unsigned Addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [7:0]            in_data,
  input  logic [Addr_width-1:0] fifo_used,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [7:0]            out_data,
  output logic                  out_sop,
  output logic [15:0]           null_cnt,
  output logic [15:0]           drop_cnt
);

  localparam logic [7:0]  SyncByte = 8'h47;
  localparam logic [7:0]  LastIdx  = 8'd187;
  localparam int unsigned PktLen   = 188;
  localparam logic [15:0] CntMax   = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StPass, StNull} state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic [15:0] null_cnt_q, null_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        pkt_ready;
  logic [7:0]  null_data;

  assign pkt_ready = (64'(fifo_used) >= 64'(PktLen));

  // Null packet: sync, PID 0x1FFF, payload-only adaptation field control, CC 0, then 0xFF stuffing.
  always_comb begin
    null_data = 8'hFF;
    unique case (byte_idx_q)
      8'd0:    null_data = SyncByte;
      8'd1:    null_data = 8'h1F;
      8'd2:    null_data = 8'hFF;
      8'd3:    null_data = 8'h10;
      default: null_data = 8'hFF;
    endcase
  end

  // Handshake outputs are combinational so PASS forwards bytes with zero latency.
  always_comb begin
    in_ack   = 1'b0;
    out_req  = 1'b0;
    out_data = null_data;
    out_sop  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          in_ack = pkt_ready && in_req && (in_data != SyncByte);
        end
        StPass: begin
          out_req  = in_req;
          out_data = in_data;
          in_ack   = in_req && out_ack;
          out_sop  = (byte_idx_q == 8'd0);
        end
        StNull: begin
          out_req = 1'b1;
          out_sop = (byte_idx_q == 8'd0);
        end
        default: begin
          in_ack  = 1'b0;
          out_req = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    null_cnt_d = null_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      StIdle: begin
        byte_idx_d = 8'd0;
        if (!pkt_ready) begin
          state_d = StNull;
        end else if (in_req) begin
          if (in_data == SyncByte) begin
            state_d = StPass;
          end else if (drop_cnt_q != CntMax) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      StPass: begin
        if (in_ack) begin
          if (byte_idx_q == LastIdx) begin
            state_d    = StIdle;
            byte_idx_d = 8'd0;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      StNull: begin
        if (out_ack) begin
          if (byte_idx_q == LastIdx) begin
            state_d    = StIdle;
            byte_idx_d = 8'd0;
            if (null_cnt_q != CntMax) begin
              null_cnt_d = null_cnt_q + 16'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        byte_idx_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_idx_q <= 8'd0;
      null_cnt_q <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      null_cnt_q <= null_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign null_cnt = null_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_zl_ts_null_insert.sv
// Directed bench for zl_ts_null_insert: a queue models the show-ahead source FIFO.
module tb_zl_ts_null_insert;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_req;
  logic          in_ack;
  logic [7:0]    in_data;
  logic [AW-1:0] fifo_used;
  logic          out_req;
  logic          out_ack;
  logic [7:0]    out_data;
  logic          out_sop;
  logic [15:0]   null_cnt;
  logic [15:0]   drop_cnt;

  logic [7:0] q[$];
  logic [7:0] obs_data[$];
  logic       obs_sop[$];
  logic [7:0] exp_data[$];
  int         ack_cnt;
  int         bad_ack;
  bit         rand_ack;
  int         checks;
  int         errors;

  zl_ts_null_insert #(.Addr_width(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .fifo_used(fifo_used),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .out_sop  (out_sop),
    .null_cnt (null_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] null_byte(int i);
    case (i)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] pkt_byte(int p, int i);
    if (i == 0) return 8'h47;
    return 8'((i - 1 + p * 3) & 255);
  endfunction

  task automatic push_pkt(int p);
    for (int i = 0; i < 188; i++) q.push_back(pkt_byte(p, i));
  endtask

  task automatic exp_pkt(int p);
    for (int i = 0; i < 188; i++) exp_data.push_back(pkt_byte(p, i));
  endtask

  task automatic exp_null();
    for (int i = 0; i < 188; i++) exp_data.push_back(null_byte(i));
  endtask

  // One clock: drive from the FIFO model at negedge, sample #1 later, commit handshakes.
  task automatic step();
    in_req    = (q.size() != 0);
    in_data   = (q.size() != 0) ? q[0] : 8'h00;
    fifo_used = (q.size() > 1023) ? 10'd1023 : 10'(q.size());
    out_ack   = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (in_ack && !in_req) bad_ack++;
    if (in_ack) begin
      void'(q.pop_front());
      ack_cnt++;
    end
    if (out_req && out_ack) begin
      obs_data.push_back(out_data);
      obs_sop.push_back(out_sop);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    rand_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    obs_data.delete();
    obs_sop.delete();
    exp_data.delete();
    ack_cnt = 0;
    bad_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_req = 1'b1; in_data = 8'h47; fifo_used = 10'd200; out_ack = 1'b1;
    #1;
    checks++;
    if ({out_req, in_ack, out_sop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: req/ack/sop=%b required 000", {out_req, in_ack, out_sop});
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_req, in_ack} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: req/ack=%b required 00", {out_req, in_ack});
    end
    checks++;
    if (null_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: null=%0d drop=%0d required 0 0", null_cnt, drop_cnt);
    end
    @(posedge clk); @(negedge clk);
    #1;
    checks++;
    if ({out_req, in_ack, out_sop, out_data} !== {3'b111, 8'h47}) begin
      errors++;
      $display("FAIL pass_first: req/ack/sop/data=%b %h required 111 47",
               {out_req, in_ack, out_sop}, out_data);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_stream(string name);
    int nbad = 0;
    int first = -1;
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i >= obs_data.size() || obs_data[i] !== exp_data[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (nbad != 0 || obs_data.size() != exp_data.size()) begin
      errors++;
      if (first >= 0 && first < obs_data.size())
        $display("FAIL %s: byte %0d got %h required %h (%0d bad, %0d of %0d bytes)", name, first,
                 obs_data[first], exp_data[first], nbad, obs_data.size(), exp_data.size());
      else
        $display("FAIL %s: got %0d bytes required %0d", name, obs_data.size(), exp_data.size());
    end
  endtask

  task automatic check_sops(string name);
    int nbad = 0;
    for (int i = 0; i < obs_sop.size(); i++)
      if (obs_sop[i] !== ((i % 188) == 0)) nbad++;
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL %s: %0d misplaced sop flags, required 0", name, nbad);
    end
  endtask

  task automatic test_null();
    int cyc = 0;
    do_reset();
    while (obs_data.size() < 564 && cyc < 1000) begin
      step();
      cyc++;
    end
    repeat (3) exp_null();
    check_stream("null_stream");
    check_sops("null_sop");
    checks++;
    if (cyc != 567) begin
      errors++;
      $display("FAIL null_timing: %0d cycles for 3 packets required 567", cyc);
    end
    checks++;
    if (null_cnt !== 16'd3 || ack_cnt != 0) begin
      errors++;
      $display("FAIL null_counts: null_cnt=%0d in_ack=%0d required 3 0", null_cnt, ack_cnt);
    end
  endtask

  task automatic test_pass();
    int cyc = 0;
    do_reset();
    push_pkt(0);
    push_pkt(1);
    while (obs_data.size() < 376 && cyc < 1000) begin
      step();
      cyc++;
    end
    exp_pkt(0);
    exp_pkt(1);
    check_stream("pass_stream");
    check_sops("pass_sop");
    checks++;
    if (ack_cnt != 376 || null_cnt !== 16'd0 || bad_ack != 0) begin
      errors++;
      $display("FAIL pass_counts: acks=%0d null=%0d bad=%0d required 376 0 0",
               ack_cnt, null_cnt, bad_ack);
    end
  endtask

  task automatic test_drop();
    int cyc = 0;
    do_reset();
    q.push_back(8'h12);
    q.push_back(8'h34);
    push_pkt(2);
    while (obs_data.size() < 188 && cyc < 500) begin
      step();
      cyc++;
    end
    exp_pkt(2);
    check_stream("drop_stream");
    check_sops("drop_sop");
    checks++;
    if (drop_cnt !== 16'd2 || ack_cnt != 190) begin
      errors++;
      $display("FAIL drop_counts: drop=%0d acks=%0d required 2 190", drop_cnt, ack_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    bit pushed = 1'b0;
    do_reset();
    rand_ack = 1'b1;
    push_pkt(1);
    while (obs_data.size() < 564 && cyc < 5000) begin
      step();
      cyc++;
      if (!pushed && obs_data.size() >= 288) begin
        push_pkt(3);
        pushed = 1'b1;
      end
    end
    rand_ack = 1'b0;
    exp_pkt(1);
    exp_null();
    exp_pkt(3);
    check_stream("randack_stream");
    check_sops("randack_sop");
    checks++;
    if (null_cnt !== 16'd1 || ack_cnt != 376 || bad_ack != 0) begin
      errors++;
      $display("FAIL randack_counts: null=%0d acks=%0d bad=%0d required 1 376 0",
               null_cnt, ack_cnt, bad_ack);
    end
  endtask

  task automatic test_reset_mid_pass();
    int cyc = 0;
    do_reset();
    q.push_back(8'h99);
    push_pkt(0);
    push_pkt(3);
    while (obs_data.size() < 100 && cyc < 500) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ack_cnt != 101 || obs_data.size() != 100) begin
      errors++;
      $display("FAIL rst_mid_hold: acks=%0d outs=%0d required 101 100", ack_cnt, obs_data.size());
    end
    checks++;
    if (null_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_counters: null=%0d drop=%0d required 0 0", null_cnt, drop_cnt);
    end
    step();
    checks++;
    if (drop_cnt !== 16'd1 || obs_data.size() != 100) begin
      errors++;
      $display("FAIL rst_mid_idle: drop=%0d outs=%0d required 1 100", drop_cnt, obs_data.size());
    end
    cyc = 0;
    while (obs_data.size() < 288 && cyc < 1000) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 100; i++) exp_data.push_back(pkt_byte(0, i));
    exp_pkt(3);
    check_stream("rst_mid_stream");
    checks++;
    if (drop_cnt !== 16'd88 || ack_cnt != 377 || obs_sop.size() != 288 || obs_sop[100] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_resync: drop=%0d acks=%0d outs=%0d required 88 377 288",
               drop_cnt, ack_cnt, obs_sop.size());
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    in_req = 1'b1; in_data = 8'h00; fifo_used = 10'd200; out_ack = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    checks++;
    if (drop_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL drop_near_sat: drop=%h required fffe", drop_cnt);
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (drop_cnt !== 16'hFFFF || out_req !== 1'b0) begin
      errors++;
      $display("FAIL drop_sat: drop=%h req=%b required ffff 0", drop_cnt, out_req);
    end
  endtask

  initial begin
    checks = 0; errors = 0; ack_cnt = 0; bad_ack = 0; rand_ack = 1'b0;
    rst = 1'b1; in_req = 1'b0; in_data = 8'h00; fifo_used = '0; out_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_null();
    test_pass();
    test_drop();
    test_back_to_back();
    test_reset_mid_pass();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
